cpu_ctrl: RTL
=============

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter RETIRE_W, default 8, SHALL set the width of the retired-instruction counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 INS  input  11  SHALL be the current instruction word from program ROM, addressed by the PC.
REQ-005 alu_eq  input  1  SHALL be the ALU equality flag.
REQ-006 set_pc  output  1  SHALL force the PC register to 0 at the next clk edge.
REQ-007 pc_en  output  1  SHALL enable the PC register update for one cycle.
REQ-008 pc_jmp  output  1  SHALL select PC+INS[7:4] (1) or PC+1 (0) when pc_en is high.
REQ-009 ir_load  output  1  SHALL load the instruction register.
REQ-010 ALU_OP  output  2  SHALL select the ALU operation: 00 add, 01 sub, 10 pass-B.
REQ-011 reg_we / REG_WADDR  output  1 / 2  SHALL write the register file at INS[3:2].
REQ-012 halted  output  1  SHALL be high while in HALT.
REQ-013 STATE / RETIRED  output  3 / RETIRE_W  SHALL expose the FSM state and the retired-instruction count.

Function
REQ-014 Opcode = INS[10:8]: 000 ADD, 001 SUB, 010 LDI, 011 NOP, 100 BEQ, 101 JMP, 110 NOP, 111 HLT.
REQ-015 FSM states SHALL be RST(0), FETCH(1), DECODE(2), EXEC(3), WB(4), HALT(5); all outputs are registered Moore outputs of the state and the latched opcode.
REQ-016 RST SHALL assert set_pc=1 for exactly one cycle after rst_n deasserts, then go to FETCH.
REQ-017 FETCH SHALL assert ir_load=1, then go to DECODE.
REQ-018 DECODE SHALL latch the opcode. HLT goes to HALT; all others go to EXEC.
REQ-019 EXEC SHALL drive ALU_OP (ADD 00, SUB 01, LDI 10, BEQ 01, others 00) and sample alu_eq into eq_q at the cycle end.
REQ-020 WB SHALL assert pc_en=1 for one cycle:
- pc_jmp=1 for JMP, and for BEQ when eq_q=1; otherwise pc_jmp=0.
- reg_we=1 only for ADD, SUB and LDI.
- WB then goes to FETCH.
REQ-021 Instruction latency SHALL be exactly 4 cycles (FETCH..WB); pc_en SHALL never be high outside WB.
REQ-022 Jump target SHALL be PC+INS[7:4] modulo 16; wrap from PC 15 to 0 on +1 is legal and unflagged.
REQ-023 HALT SHALL hold all enables at 0 and halted=1 until reset; HLT does not increment RETIRED.
REQ-024 RETIRED SHALL increment in WB and saturate at all-ones.
REQ-025 Unused state encodings SHALL go to RST on the next edge.

Reset
REQ-026 While rst_n=0 at a clk edge, the FSM SHALL enter RST:
- set_pc=1;
- RETIRED=0, eq_q=0;
- all other outputs 0.
REQ-027 Reset asserted mid-instruction (any state) SHALL abort the instruction with no reg_we or pc_en pulse on the following cycle.

Configuration
REQ-028 With CPU_CTRL_SINGLE_STEP_EN defined:
- an input port step (1 bit) SHALL be added;
- the FSM SHALL remain in FETCH, with ir_load=0, until step=1 is sampled;
- it then loads the instruction and proceeds as normal.
REQ-029 Without CPU_CTRL_SINGLE_STEP_EN, the step port SHALL be absent and FETCH SHALL last exactly one cycle.

Structure
REQ-030 A shared package SHALL hold the opcode constants, the state encodings, the ALU_OP encodings and the INS field positions (opcode 10:8, offset 7:4, waddr 3:2).
REQ-031 One sub-module, cpu_ctrl_retire_cnt (saturating counter with clear), SHALL hold the RETIRED logic; the FSM stays in cpu_ctrl.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles, then release.
- Expected: set_pc=1 during reset and for 1 cycle after; FETCH follows; RETIRED=0.
REQ-033 ADD: INS=000_0000_1000.
- Expected: ir_load in cycle 1, ALU_OP=00 in cycle 3, then reg_we=1 with REG_WADDR=2, pc_en=1, pc_jmp=0 in cycle 4; RETIRED=1.
REQ-034 BEQ taken vs not taken: INS=100_0011_0000.
- With alu_eq=1 in EXEC: pc_jmp=1 in WB (PC 14 -> 1 via wrap).
- With alu_eq=0: pc_jmp=0 in WB.
REQ-035 HLT: INS=111_xxxx_xxxx.
- Expected: halted=1 from cycle 3 onward; pc_en stays 0 for 20 cycles; RETIRED unchanged.
REQ-036 Mid-instruction reset: drop rst_n in EXEC of a SUB.
- Expected: no reg_we or pc_en pulse; RST then FETCH; RETIRED=0.
REQ-037 With CPU_CTRL_SINGLE_STEP_EN: hold step=0 for 10 cycles.
- Expected: FSM stays in FETCH with ir_load=0.
- A 1-cycle step pulse yields exactly one 4-cycle instruction.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu_ctrl instruction controller: instruction fields,
// opcodes, FSM states and ALU operation selects.
package cpu_ctrl_pkg;

  localparam int INS_W    = 11;
  localparam int OPC_HI   = 10;
  localparam int OPC_LO   = 8;
  localparam int OFS_HI   = 7;
  localparam int OFS_LO   = 4;
  localparam int WADDR_HI = 3;
  localparam int WADDR_LO = 2;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_LDI   = 3'b010,
    OP_NOP_A = 3'b011,
    OP_BEQ   = 3'b100,
    OP_JMP   = 3'b101,
    OP_NOP_B = 3'b110,
    OP_HLT   = 3'b111
  } opcode_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_B = 2'b10;

  // BEQ compares by subtraction, so it shares the SUB select.
  function automatic logic [1:0] alu_sel(opcode_t op);
    case (op)
      OP_SUB, OP_BEQ: return ALU_SUB;
      OP_LDI:         return ALU_PASS_B;
      default:        return ALU_ADD;
    endcase
  endfunction

  function automatic logic writes_reg(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/cpu_ctrl_retire_cnt.sv
// Saturating retired-instruction counter with synchronous clear.
module cpu_ctrl_retire_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/WB controller with registered Moore outputs.
// Define CPU_CTRL_SINGLE_STEP_EN to add a step input that gates each FETCH.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [INS_W-1:0]    INS,
  input  logic                alu_eq,
  output logic                set_pc,
  output logic                pc_en,
  output logic                pc_jmp,
  output logic                ir_load,
  output logic [1:0]          ALU_OP,
  output logic                reg_we,
  output logic [1:0]          REG_WADDR,
  output logic                halted,
  output logic [2:0]          STATE,
  output logic [RETIRE_W-1:0] RETIRED
);

  state_t     state, state_n;
  opcode_t    op_q, op_n;
  logic       eq_q, eq_n;
  logic [1:0] waddr_q, waddr_n;

  logic       set_pc_n, pc_en_n, pc_jmp_n, ir_load_n, reg_we_n, halted_n;
  logic [1:0] alu_op_n, reg_waddr_n;

  // The PC offset and low bits are consumed by the datapath, not here.
  logic unused_ins;
  assign unused_ins = ^{INS[OFS_HI:OFS_LO], INS[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RST;
      op_q      <= OP_NOP_A;
      eq_q      <= 1'b0;
      waddr_q   <= 2'b00;
      set_pc    <= 1'b1;
      pc_en     <= 1'b0;
      pc_jmp    <= 1'b0;
      ir_load   <= 1'b0;
      ALU_OP    <= ALU_ADD;
      reg_we    <= 1'b0;
      REG_WADDR <= 2'b00;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      eq_q      <= eq_n;
      waddr_q   <= waddr_n;
      set_pc    <= set_pc_n;
      pc_en     <= pc_en_n;
      pc_jmp    <= pc_jmp_n;
      ir_load   <= ir_load_n;
      ALU_OP    <= alu_op_n;
      reg_we    <= reg_we_n;
      REG_WADDR <= reg_waddr_n;
      halted    <= halted_n;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    eq_n        = eq_q;
    waddr_n     = waddr_q;
    set_pc_n    = 1'b0;
    pc_en_n     = 1'b0;
    pc_jmp_n    = 1'b0;
    ir_load_n   = 1'b0;
    alu_op_n    = ALU_ADD;
    reg_we_n    = 1'b0;
    reg_waddr_n = 2'b00;
    halted_n    = 1'b0;

    case (state)
      S_RST:   state_n = S_FETCH;
      S_FETCH: begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
        if (ir_load) begin
          state_n = S_DECODE;
        end else if (step) begin
          ir_load_n = 1'b1;
        end
`else
        state_n = S_DECODE;
`endif
      end
      S_DECODE: begin
        op_n    = opcode_t'(INS[OPC_HI:OPC_LO]);
        waddr_n = INS[WADDR_HI:WADDR_LO];
        state_n = (op_n == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        eq_n    = alu_eq;
        state_n = S_WB;
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_RST;
    endcase

    case (state_n)
      S_RST:   set_pc_n = 1'b1;
      S_FETCH: begin
`ifndef CPU_CTRL_SINGLE_STEP_EN
        ir_load_n = 1'b1;
`endif
      end
      S_EXEC:  alu_op_n = alu_sel(op_n);
      S_WB: begin
        pc_en_n     = 1'b1;
        pc_jmp_n    = (op_n == OP_JMP) || ((op_n == OP_BEQ) && eq_n);
        reg_we_n    = writes_reg(op_n);
        reg_waddr_n = waddr_n;
      end
      S_HALT:  halted_n = 1'b1;
      default: ;
    endcase
  end

  assign STATE = state;

  cpu_ctrl_retire_cnt #(
    .W(RETIRE_W)
  ) u_retire_cnt (
    .clk  (clk),
    .clr  (!rst_n),
    .inc  (state == S_WB),
    .count(RETIRED)
  );

endmodule
